// File: rtl/adam_axil_apb_bridge_mc.sv
// rtl/adam_axil_apb_bridge_mc.sv - AXI-Lite slave to multi-port APB master bridge
// One transaction at a time, region decode, pready watchdog, fair R/W arbitration, pause handshake.
module adam_axil_apb_bridge_mc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NO_MSTS    = 8,
  parameter int INC        = 1024,
  parameter int TIMEOUT    = 256,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic [ADDR_WIDTH-1:0]         aw_addr,
  input  logic [2:0]                    aw_prot,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [STRB_WIDTH-1:0]         w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         ar_addr,
  input  logic [2:0]                    ar_prot,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [2:0]                    pprot,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_WIDTH-1:0]         pstrb,
  output logic [NO_MSTS-1:0]            psel,
  output logic                          penable,
  input  logic [NO_MSTS*DATA_WIDTH-1:0] prdata,
  input  logic [NO_MSTS-1:0]            pready,
  input  logic [NO_MSTS-1:0]            pslverr
);

  localparam int OFFW = $clog2(INC);
  localparam int IDXW = ADDR_WIDTH - OFFW;
  localparam int IW   = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, PAUSED} state_t;
  state_t state, state_nxt;

  logic                  prio_w, is_write;
  logic [IW-1:0]         sel_idx;
  logic [CW-1:0]         wd_cnt;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  cand_w, cand_r, idle_go, grant_w, grant_r, grant, g_mapped;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [2:0]            g_prot;
  logic [IDXW-1:0]       g_idx;
  logic                  sel_ready, sel_err, wd_expire, resp_hs;
  logic [DATA_WIDTH-1:0] sel_prdata;

  always_comb begin
    cand_w   = aw_valid && w_valid;
    cand_r   = ar_valid;
    idle_go  = !rst && (state == IDLE) && !pause_req;
    grant_w  = idle_go && cand_w && (!cand_r || prio_w);
    grant_r  = idle_go && cand_r && (!cand_w || !prio_w);
    grant    = grant_w || grant_r;
    g_addr   = grant_w ? aw_addr : ar_addr;
    g_prot   = grant_w ? aw_prot : ar_prot;
    g_idx    = g_addr[ADDR_WIDTH-1:OFFW];
    g_mapped = ADDR_WIDTH'(g_idx) < ADDR_WIDTH'(NO_MSTS);
  end

  always_comb begin
    sel_prdata = prdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_ready  = pready[sel_idx];
    sel_err    = pslverr[sel_idx];
    // Expires on the TIMEOUT-th ACCESS cycle that still lacks pready.
    wd_expire  = (TIMEOUT != 0) && !sel_ready && (wd_cnt == CW'(TIMEOUT - 1));
    resp_hs    = is_write ? b_ready : r_ready;
  end

  always_comb begin
    aw_ready  = grant_w;
    w_ready   = grant_w;
    ar_ready  = grant_r;
    b_valid   = (state == RESP) && is_write;
    r_valid   = (state == RESP) && !is_write;
    b_resp    = resp_q;
    r_resp    = resp_q;
    r_data    = rdata_q;
    pause_ack = (state == PAUSED);
    penable   = (state == ACCESS);
    psel      = '0;
    if (state == SETUP || state == ACCESS) psel[sel_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pause_req) state_nxt = PAUSED;
               else if (grant) state_nxt = g_mapped ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_ready || wd_expire) state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = pause_req ? PAUSED : IDLE;
      PAUSED:  if (!pause_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio_w   <= 1'b1;
      is_write <= 1'b0;
      sel_idx  <= '0;
      wd_cnt   <= '0;
      resp_q   <= OKAY;
      rdata_q  <= '0;
      paddr    <= '0;
      pprot    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pstrb    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        is_write <= grant_w;
        sel_idx  <= g_idx[IW-1:0];
        paddr    <= ADDR_WIDTH'(g_addr[OFFW-1:0]);
        pprot    <= g_prot;
        pwrite   <= grant_w;
        pwdata   <= grant_w ? w_data : '0;
        pstrb    <= grant_w ? w_strb : '0;
        rdata_q  <= '0;
        resp_q   <= g_mapped ? OKAY : DECERR;
        wd_cnt   <= '0;
        // Only contention flips the priority; a lone requester does not.
        if (cand_w && cand_r) prio_w <= !prio_w;
      end
      if (state == ACCESS) begin
        if (sel_ready) begin
          rdata_q <= sel_prdata;
          resp_q  <= sel_err ? SLVERR : OKAY;
        end else if (wd_expire) begin
          resp_q  <= SLVERR;
        end else begin
          wd_cnt  <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adam_axil_apb_bridge_mc.sv
// tb/tb_adam_axil_apb_bridge_mc.sv - self-checking bench for adam_axil_apb_bridge_mc
module tb_adam_axil_apb_bridge_mc;
  localparam int AW = 32, DW = 32, SW = 4, NO = 8, INC = 1024, TO = 16;

  logic clk = 1'b0, rst = 1'b1, pause_req = 1'b0, pause_ack;
  logic [AW-1:0] aw_addr = '0, ar_addr = '0, paddr;
  logic [2:0] aw_prot = '0, ar_prot = '0, pprot;
  logic aw_valid = 1'b0, aw_ready, w_valid = 1'b0, w_ready, ar_valid = 1'b0, ar_ready;
  logic [DW-1:0] w_data = '0, r_data, pwdata;
  logic [SW-1:0] w_strb = '0, pstrb;
  logic [1:0] b_resp, r_resp;
  logic b_valid, b_ready = 1'b1, r_valid, r_ready = 1'b1, pwrite, penable;
  logic [NO-1:0] psel, pready, pslverr;
  logic [NO*DW-1:0] prdata;

  adam_axil_apb_bridge_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MSTS(NO), .INC(INC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  always #5 clk = ~clk;

  // APB slave models: each port waits wait_q[i] ACCESS cycles before pready.
  int wait_q[NO];
  bit err_q[NO];
  logic [DW-1:0] slave_data[NO];
  int acc_cnt = 0;
  for (genvar i = 0; i < NO; i++) begin : g_slv
    assign pready[i]  = psel[i] && penable && (acc_cnt >= wait_q[i]);
    assign pslverr[i] = err_q[i];
    assign prdata[i*DW +: DW] = slave_data[i];
  end
  always @(posedge clk)
    if (penable && psel != 0 && (psel & pready) == 0) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  int vectors = 0, errors = 0;
  int cyc = 0, grant_cyc = 0, last_lat = 0, acc_cycles = 0, psel_cycles = 0, onehot_bad = 0, paused_ready = 0;
  logic [NO-1:0] last_psel = '0;
  logic [AW-1:0] last_paddr = '0;
  logic [DW-1:0] seen_wdata = '0;
  bit grant_log[$];
  logic [1:0] bq[$];
  logic [DW+1:0] rq[$];

  // Monitor samples one time unit before each rising edge.
  initial forever begin
    @(negedge clk); #4;
    cyc++;
    if (!rst) begin
      if (pause_ack && (aw_ready || w_ready || ar_ready)) paused_ready++;
      if (aw_valid && aw_ready && w_valid && w_ready) begin grant_log.push_back(1'b1); acc_cycles = 0; grant_cyc = cyc; end
      if (ar_valid && ar_ready) begin grant_log.push_back(1'b0); acc_cycles = 0; grant_cyc = cyc; end
      if (psel != 0) begin
        psel_cycles++; last_psel = psel; last_paddr = paddr;
        if (!$onehot(psel)) onehot_bad++;
        if (penable) acc_cycles++;
        if (penable && pwrite && (psel & pready) != 0) seen_wdata = pwdata;
      end
      if (b_valid && b_ready) begin bq.push_back(b_resp); last_lat = cyc - grant_cyc; end
      if (r_valid && r_ready) begin rq.push_back({r_resp, r_data}); last_lat = cyc - grant_cyc; end
    end
  end

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int idx; bit mapped; bit chk_data;
    logic [1:0] exp_resp; logic [DW-1:0] exp_rdata; logic [AW-1:0] exp_paddr; int exp_lat; int exp_acc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++; errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  // Reference: decode by plain arithmetic, outcome from the slave configuration.
  function automatic vec_t ref_model(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.idx = int'(addr / INC); v.exp_paddr = addr % INC;
    v.mapped = (addr / INC) < NO;
    v.exp_rdata = '0; v.exp_acc = 0; v.chk_data = 1'b1;
    if (!v.mapped) begin
      v.exp_resp = 2'b11; v.exp_lat = 1;
    end else if (wait_q[v.idx] >= TO) begin
      v.exp_resp = 2'b10; v.exp_lat = TO + 2; v.exp_acc = TO; v.chk_data = 1'b0;
    end else begin
      v.exp_resp = err_q[v.idx] ? 2'b10 : 2'b00;
      v.exp_rdata = slave_data[v.idx];
      v.exp_lat = 3 + wait_q[v.idx]; v.exp_acc = wait_q[v.idx] + 1;
    end
    return v;
  endfunction

  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output logic [1:0] resp, output logic [DW-1:0] rd, output bit ok);
    int g0;
    g0 = grant_log.size(); ok = 1'b0; resp = '0; rd = '0;
    @(negedge clk);
    if (wr) begin
      aw_addr = addr; aw_prot = 3'($urandom); w_data = data; w_strb = 4'($urandom);
      aw_valid = 1'b1; w_valid = 1'b1;
    end else begin
      ar_addr = addr; ar_prot = 3'($urandom); ar_valid = 1'b1;
    end
    for (int k = 0; k < 20 && grant_log.size() == g0; k++) @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    if (grant_log.size() == g0) begin fail_now("grant"); return; end
    for (int k = 0; k < 60 && (wr ? bq.size() == 0 : rq.size() == 0); k++) @(negedge clk);
    if (wr ? bq.size() == 0 : rq.size() == 0) begin fail_now("response"); return; end
    if (wr) resp = bq.pop_front();
    else {resp, rd} = rq.pop_front();
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] resp;
    logic [DW-1:0] rd;
    logic [NO-1:0] exp_sel;
    bit ok;
    int p0;
    p0 = psel_cycles;
    do_txn(v.wr, v.addr, v.wdata, resp, rd, ok);
    if (!ok) return;
    check(v.wr ? "b_resp" : "r_resp", resp, v.exp_resp);
    if (!v.wr && v.chk_data) check("r_data", rd, v.exp_rdata);
    check("latency", last_lat, v.exp_lat);
    if (v.mapped) begin
      exp_sel = '0; exp_sel[v.idx] = 1'b1;
      check("psel", last_psel, exp_sel);
      check("paddr", last_paddr, v.exp_paddr);
      check("access_cycles", acc_cycles, v.exp_acc);
      if (v.wr && v.chk_data) check("pwdata", seen_wdata, v.wdata);
    end else begin
      check("unmapped_no_psel", psel_cycles - p0, 0);
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  int g0, r0;

  initial begin
    for (int i = 0; i < NO; i++) begin
      wait_q[i] = 0; err_q[i] = 1'b0; slave_data[i] = DW'(i);
      for (int e = 0; e < 2; e++)
        for (int w = 1; w >= 0; w--) begin
          v.wr = w[0]; v.addr = AW'(INC * i + (e ? INC - 1 : 0)); v.wdata = 32'hA500_0000 | DW'(i * 2 + e);
          v.idx = i; v.mapped = 1'b1; v.chk_data = 1'b1; v.exp_resp = 2'b00; v.exp_rdata = DW'(i);
          v.exp_paddr = e ? AW'(INC - 1) : '0; v.exp_lat = 3; v.exp_acc = 1;
          tbl.push_back(v);
        end
    end
    for (int w = 1; w >= 0; w--) begin
      v.wr = w[0]; v.addr = 32'd8192; v.wdata = 32'hDEAD_0008; v.idx = 8; v.mapped = 1'b0; v.chk_data = 1'b1;
      v.exp_resp = 2'b11; v.exp_rdata = '0; v.exp_paddr = '0; v.exp_lat = 1; v.exp_acc = 0;
      tbl.push_back(v);
    end

    // Reset with every request asserted: nothing may be granted or driven.
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_readies", {aw_ready, w_ready, ar_ready}, 0);
    check("rst_valids", {b_valid, r_valid, pause_ack}, 0);
    check("rst_apb_ctl", {psel, penable, pwrite, pprot, pstrb}, 0);
    check("rst_apb_data", {paddr, pwdata}, 0);
    check("rst_resp", {b_resp, r_resp, r_data}, 0);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    rst = 1'b0;

    foreach (tbl[n]) run_vec(tbl[n]);

    // Simultaneous requests: priority alternates starting with write.
    wait_q[2] = 0; err_q[2] = 1'b1; slave_data[2] = 32'hC0DE_0002;
    g0 = grant_log.size();
    @(negedge clk);
    aw_addr = 2 * INC + 4; w_data = 32'h2222_2222; w_strb = 4'hF; ar_addr = 2 * INC + 8;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    for (int k = 0; k < 80 && grant_log.size() < g0 + 4; k++) @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    if (grant_log.size() < g0 + 4) fail_now("contention_grants");
    else begin
      for (int j = 0; j < 4; j++) check("grant_order", grant_log[g0+j], (j % 2 == 0));
      for (int k = 0; k < 40 && (bq.size() < 2 || rq.size() < 2); k++) @(negedge clk);
      if (bq.size() < 2 || rq.size() < 2) fail_now("contention_resp");
      else for (int j = 0; j < 2; j++) begin
        check("contention_b_resp", bq.pop_front(), 2'b10);
        check("contention_r", rq.pop_front(), {2'b10, 32'hC0DE_0002});
      end
    end
    err_q[2] = 1'b0;

    // Watchdog: a silent port 3 yields SLVERR after exactly TO ACCESS cycles.
    wait_q[3] = 1000;
    run_vec(ref_model(1'b1, 3 * INC + 16, 32'h1234_5678));
    @(negedge clk);
    check("timeout_psel_dropped", {psel, penable}, 0);
    wait_q[3] = 0; slave_data[3] = 32'h3333_0003;
    run_vec(ref_model(1'b0, 3 * INC + 20, '0));

    // Pause raised mid-transaction on port 5 with four wait states.
    wait_q[5] = 4; err_q[5] = 1'b0;
    g0 = grant_log.size();
    @(negedge clk);
    aw_addr = 5 * INC + 8; w_data = 32'h5555_AAAA; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    for (int k = 0; k < 20 && grant_log.size() == g0; k++) @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int k = 0; k < 10 && !penable; k++) @(negedge clk);
    pause_req = 1'b1;
    @(negedge clk);
    check("pause_ack_midtxn", pause_ack, 0);
    for (int k = 0; k < 30 && bq.size() == 0; k++) @(negedge clk);
    if (bq.size() == 0) fail_now("pause_txn");
    else begin
      check("pause_txn_resp", bq.pop_front(), 2'b00);
      check("pause_ack_after_b", pause_ack, 1);
    end
    r0 = paused_ready; g0 = grant_log.size();
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("paused_no_ready", paused_ready - r0, 0);
    check("paused_no_grant", grant_log.size() - g0, 0);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    @(negedge clk);
    pause_req = 1'b0;
    #1 check("pause_ack_hold", pause_ack, 1);
    @(negedge clk);
    check("pause_ack_clear", pause_ack, 0);
    pause_req = 1'b1;
    @(negedge clk);
    check("idle_pause_ack", pause_ack, 1);
    pause_req = 1'b0;
    @(negedge clk);
    check("idle_pause_release", pause_ack, 0);
    wait_q[5] = 0;

    // Reset during ACCESS drops everything; bridge recovers.
    wait_q[3] = 1000;
    g0 = grant_log.size();
    @(negedge clk);
    aw_addr = 3 * INC; w_data = 32'h0BAD_0BAD; aw_valid = 1'b1; w_valid = 1'b1;
    for (int k = 0; k < 20 && grant_log.size() == g0; k++) @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_in_access", penable, 1);
    rst = 1'b1; aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_apb", {psel, penable}, 0);
    check("rst_mid_valids", {b_valid, r_valid, pause_ack}, 0);
    check("rst_mid_readies", {aw_ready, w_ready, ar_ready}, 0);
    @(negedge clk);
    rst = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    wait_q[3] = 0;
    run_vec(ref_model(1'b1, 3 * INC + 4, 32'hBEEF_0003));

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      int idx;
      logic [AW-1:0] addr;
      idx = $urandom_range(0, NO + 1);
      addr = AW'(idx * INC + $urandom_range(0, INC - 1));
      if (n % 15 == 14) addr = 32'hFFFF_FFF0;
      if (idx < NO) begin
        wait_q[idx] = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 3);
        err_q[idx] = 1'($urandom_range(0, 1));
        slave_data[idx] = $urandom;
      end
      run_vec(ref_model(1'($urandom_range(0, 1)), addr, $urandom));
    end

    check("psel_onehot", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
